// File: rtl/addsub_arbiter_pkg.sv
// Shared types for the two-requester add/sub arbiter: FSM encoding,
// requester index width and the latched operation / result records.
package addsub_arbiter_pkg;
   localparam int ID_W   = 1;
   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              sub;
      logic [ID_W-1:0]   id;
   } op_t;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              carry;
      logic              overflow;
      logic [ID_W-1:0]   id;
   } rsp_t;
endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester, response and display signals of the add/sub arbiter.
// slave = arbiter side, master = requesters/consumer side.
interface addsub_arbiter_if;
   import addsub_arbiter_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              req0_sub;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              req1_sub;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [DATA_W-1:0] rsp_d;
   logic              rsp_carry;
   logic              rsp_overflow;

   logic [DATA_W-1:0] disp_val;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      input  req1_valid, req1_a, req1_b, req1_sub,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_d, rsp_carry, rsp_overflow,
      output disp_val
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      output req1_valid, req1_a, req1_b, req1_sub,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_d, rsp_carry, rsp_overflow,
      input  disp_val
   );
endinterface

// File: rtl/addsub_arbiter_four_bit_adder_sub.sv
// Ripple-carry 4-bit adder/subtractor: d = a + (b ^ {sub}) + sub.
// Overflow is the carry into the sign bit xor the carry out of it.
module four_bit_adder_sub
   import addsub_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] d,
   output logic              carry,
   output logic              overflow
);
   logic [DATA_W:0] c;

   assign c[0] = sub;

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      logic bx;
      assign bx       = b[i] ^ sub;
      assign d[i]     = a[i] ^ bx ^ c[i];
      assign c[i+1]   = (a[i] & bx) | (c[i] & (a[i] ^ bx));
   end

   assign carry    = c[DATA_W];
   assign overflow = c[DATA_W-1] ^ c[DATA_W];
endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of one shared add/sub datapath.
// IDLE grants and latches an op, EXEC registers the result, RESP holds it.
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   addsub_arbiter_if.slave  bus
);
   state_t            state_q, state_d;
   op_t               op_q;
   rsp_t              rsp_q;
   logic [DATA_W-1:0] disp_q;
   logic [ID_W-1:0]   prio_q;

   logic              any_v;
   logic [ID_W-1:0]   grant;
   logic              accept;
   logic              rsp_fire;

   logic [DATA_W-1:0] alu_d;
   logic              alu_carry;
   logic              alu_ovf;

   // prio_q names the requester that wins a tie; it flips away from each winner.
   always_comb begin
      any_v = bus.req0_valid | bus.req1_valid;
      grant = '0;
      if (bus.req0_valid && bus.req1_valid)
         grant = RR_EN ? prio_q : '0;
      else if (bus.req1_valid)
         grant = 1'b1;
   end

   assign accept   = (state_q == ST_IDLE) && any_v;
   assign rsp_fire = (state_q == ST_RESP) && bus.rsp_ready;

   // Readies are gated by rst_n so nothing looks accepted while in reset.
   assign bus.req0_ready = rst_n && accept && (grant == 1'b0);
   assign bus.req1_ready = rst_n && accept && (grant == 1'b1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)   state_d = ST_EXEC;
         ST_EXEC:               state_d = ST_RESP;
         ST_RESP: if (rsp_fire) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   four_bit_adder_sub u_alu (
      .a        (op_q.a),
      .b        (op_q.b),
      .sub      (op_q.sub),
      .d        (alu_d),
      .carry    (alu_carry),
      .overflow (alu_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         rsp_q  <= '0;
         disp_q <= '0;
         prio_q <= '0;
      end else begin
         if (accept) begin
            op_q.a   <= grant ? bus.req1_a   : bus.req0_a;
            op_q.b   <= grant ? bus.req1_b   : bus.req0_b;
            op_q.sub <= grant ? bus.req1_sub : bus.req0_sub;
            op_q.id  <= grant;
            prio_q   <= ~grant;
         end
         if (state_q == ST_EXEC) begin
            rsp_q.d        <= alu_d;
            rsp_q.carry    <= alu_carry;
            rsp_q.overflow <= alu_ovf;
            rsp_q.id       <= op_q.id;
         end
         if (rsp_fire)
            disp_q <= rsp_q.d;
      end
   end

   assign bus.rsp_valid    = (state_q == ST_RESP);
   assign bus.rsp_id       = rsp_q.id;
   assign bus.rsp_d        = rsp_q.d;
   assign bus.rsp_carry    = rsp_q.carry;
   assign bus.rsp_overflow = rsp_q.overflow;
   assign bus.disp_val     = disp_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench: round-robin instance for the main sequence, fixed-priority
// instance held with both requesters valid alongside it.
module tb_addsub_arbiter;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   addsub_arbiter_if rr ();
   addsub_arbiter_if fp ();

   addsub_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr));
   addsub_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fp));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic rsp_chk(input string tag, input logic [3:0] d, input logic c,
                          input logic o, input logic id);
      check({tag, "_valid"}, {7'd0, rr.rsp_valid}, 8'd1);
      check({tag, "_d"},     {4'd0, rr.rsp_d}, {4'd0, d});
      check({tag, "_carry"}, {7'd0, rr.rsp_carry}, {7'd0, c});
      check({tag, "_ovf"},   {7'd0, rr.rsp_overflow}, {7'd0, o});
      check({tag, "_id"},    {7'd0, rr.rsp_id}, {7'd0, id});
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0;
      rr.req0_valid = 0; rr.req0_a = 0; rr.req0_b = 0; rr.req0_sub = 0;
      rr.req1_valid = 0; rr.req1_a = 0; rr.req1_b = 0; rr.req1_sub = 0;
      rr.rsp_ready  = 1;
      fp.req0_valid = 1; fp.req0_a = 4'd1; fp.req0_b = 4'd1; fp.req0_sub = 0;
      fp.req1_valid = 1; fp.req1_a = 4'd7; fp.req1_b = 4'd7; fp.req1_sub = 0;
      fp.rsp_ready  = 1;

      // reset: requester valid during reset must not see a ready
      rr.req0_valid = 1;
      tick(); tick();
      check("rst_valid", {7'd0, rr.rsp_valid}, 8'd0);
      check("rst_rdy0",  {7'd0, rr.req0_ready}, 8'd0);
      check("rst_d",     {4'd0, rr.rsp_d}, 8'd0);
      check("rst_disp",  {4'd0, rr.disp_val}, 8'd0);
      rr.req0_valid = 0;
      rst_n = 1'b1;

      // 5 + 3
      rr.req0_valid = 1; rr.req0_a = 4'd5; rr.req0_b = 4'd3; rr.req0_sub = 0;
      #1;
      check("add_rdy0", {7'd0, rr.req0_ready}, 8'd1);
      check("add_rdy1", {7'd0, rr.req1_ready}, 8'd0);
      tick();
      rr.req0_valid = 0;
      #1;
      check("add_exec_valid", {7'd0, rr.rsp_valid}, 8'd0);
      tick();
      rsp_chk("add", 4'h8, 1'b0, 1'b1, 1'b0);
      tick();
      check("add_done_valid", {7'd0, rr.rsp_valid}, 8'd0);
      check("add_disp", {4'd0, rr.disp_val}, 8'h08);

      // 3 - 5 on requester 1
      rr.req1_valid = 1; rr.req1_a = 4'd3; rr.req1_b = 4'd5; rr.req1_sub = 1;
      #1;
      check("sub_rdy1", {7'd0, rr.req1_ready}, 8'd1);
      tick();
      rr.req1_valid = 0;
      tick();
      rsp_chk("sub", 4'hE, 1'b0, 1'b0, 1'b1);
      tick();
      check("sub_disp", {4'd0, rr.disp_val}, 8'h0E);

      // both valid after reset: rr alternates, fp stays on req0
      rst_n = 1'b0;
      #1;
      check("rst2_disp", {4'd0, rr.disp_val}, 8'd0);
      tick();
      rst_n = 1'b1;
      rr.req0_valid = 1; rr.req0_a = 4'd1; rr.req0_b = 4'd1; rr.req0_sub = 0;
      rr.req1_valid = 1; rr.req1_a = 4'd7; rr.req1_b = 4'd7; rr.req1_sub = 0;
      #1;
      check("rr1_rdy0", {7'd0, rr.req0_ready}, 8'd1);
      check("rr1_rdy1", {7'd0, rr.req1_ready}, 8'd0);
      check("fp1_rdy0", {7'd0, fp.req0_ready}, 8'd1);
      tick();
      check("rr_exec_rdy0", {7'd0, rr.req0_ready}, 8'd0);
      check("rr_exec_rdy1", {7'd0, rr.req1_ready}, 8'd0);
      tick();
      rsp_chk("rr1", 4'h2, 1'b0, 1'b0, 1'b0);
      check("fp1_id", {7'd0, fp.rsp_id}, 8'd0);
      tick();
      check("rr2_rdy0", {7'd0, rr.req0_ready}, 8'd0);
      check("rr2_rdy1", {7'd0, rr.req1_ready}, 8'd1);
      check("fp2_rdy0", {7'd0, fp.req0_ready}, 8'd1);
      check("fp2_rdy1", {7'd0, fp.req1_ready}, 8'd0);
      tick();
      rr.req0_valid = 0; rr.req1_valid = 0;
      tick();
      rsp_chk("rr2", 4'hE, 1'b0, 1'b1, 1'b1);
      check("fp2_id", {7'd0, fp.rsp_id}, 8'd0);
      check("fp2_d",  {4'd0, fp.rsp_d}, 8'h02);
      tick();

      // consumer stall: 6 - 2 held in RESP for four cycles
      rr.rsp_ready = 0;
      rr.req0_valid = 1; rr.req0_a = 4'd6; rr.req0_b = 4'd2; rr.req0_sub = 1;
      tick();
      rr.req0_valid = 0;
      rr.req1_valid = 1; rr.req1_a = 4'd2; rr.req1_b = 4'd2; rr.req1_sub = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         rsp_chk("stall", 4'h4, 1'b1, 1'b0, 1'b0);
         check("stall_rdy1", {7'd0, rr.req1_ready}, 8'd0);
         tick();
      end
      rr.rsp_ready = 1;
      #1;
      check("stall_rel_valid", {7'd0, rr.rsp_valid}, 8'd1);
      tick();
      check("stall_done_valid", {7'd0, rr.rsp_valid}, 8'd0);
      check("stall_disp", {4'd0, rr.disp_val}, 8'h04);
      check("stall_next_rdy1", {7'd0, rr.req1_ready}, 8'd1);
      tick();
      rr.req1_valid = 0;
      tick();
      rsp_chk("after_stall", 4'h4, 1'b0, 1'b0, 1'b1);
      tick();

      // reset while the op is in EXEC
      rr.req0_valid = 1; rr.req0_a = 4'hF; rr.req0_b = 4'hF; rr.req0_sub = 0;
      tick();
      rr.req0_valid = 0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {7'd0, rr.rsp_valid}, 8'd0);
      check("mid_rst_d",     {4'd0, rr.rsp_d}, 8'd0);
      check("mid_rst_id",    {7'd0, rr.rsp_id}, 8'd0);
      check("mid_rst_carry", {7'd0, rr.rsp_carry}, 8'd0);
      check("mid_rst_disp",  {4'd0, rr.disp_val}, 8'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rst_no_rsp", {7'd0, rr.rsp_valid}, 8'd0);
      tick();
      check("mid_rst_no_rsp2", {7'd0, rr.rsp_valid}, 8'd0);

      // F + 1 wraps with carry, no overflow
      rr.req0_valid = 1; rr.req0_a = 4'hF; rr.req0_b = 4'h1; rr.req0_sub = 0;
      tick();
      rr.req0_valid = 0;
      tick();
      rsp_chk("wrap", 4'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("wrap_done_valid", {7'd0, rr.rsp_valid}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
